// File: rtl/des_round_seq.sv
// Control sequencer for an iterative DES round engine. It walks one block through
// load, NUM_ROUNDS Feistel rounds and a final permutation, and drives the key-schedule rotations.
module des_round_seq #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_mode,
  output logic       in_ready,
  input  logic       abort,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic [3:0] dp_round_idx,
  output logic [1:0] ks_shift,
  output logic       ks_dir,
  output logic       dp_final,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_mode,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mode_q, mode_nxt;

  // Decryption rotates right and skips the rotate on the first round, since
  // the schedule starts from the same C/D that encryption ends with.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] idx);
    logic single;
    single = (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    if (dec && idx == 4'd0)
      return 2'd0;
    return single ? 2'd1 : 2'd2;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_q <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = LOAD;
          cnt_nxt   = 4'd0;
          mode_nxt  = in_mode;
        end
      end
      LOAD:  state_nxt = ROUND;
      ROUND: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_IDX)
          state_nxt = FINAL;
      end
      FINAL: state_nxt = DONE;
      DONE: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides everything, including an accept or a DONE handshake.
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    dp_load      = 1'b0;
    dp_round_en  = 1'b0;
    dp_round_idx = 4'd0;
    ks_shift     = 2'd0;
    ks_dir       = 1'b0;
    dp_final     = 1'b0;
    out_valid    = 1'b0;
    out_mode     = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: in_ready = 1'b1;
      LOAD: begin
        dp_load = 1'b1;
        ks_dir  = mode_q;
      end
      ROUND: begin
        dp_round_en  = 1'b1;
        dp_round_idx = cnt;
        ks_shift     = shift_amt(mode_q, cnt);
        ks_dir       = mode_q;
      end
      FINAL: dp_final = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        out_mode  = mode_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_des_round_seq.sv
// Directed bench for des_round_seq: cycle-exact checks of load/round/final/done timing,
// key-schedule shifts, abort, reset and back-to-back traffic.
module tb_des_round_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_mode = 1'b0;
  logic       in_ready;
  logic       abort = 1'b0;
  logic       dp_load;
  logic       dp_round_en;
  logic [3:0] dp_round_idx;
  logic [1:0] ks_shift;
  logic       ks_dir;
  logic       dp_final;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_mode;
  logic       busy;

  int nvec = 0;
  int nerr = 0;
  logic mon_on = 1'b0;

  logic [1:0] enc_sh [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] dec_sh [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                              2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // {in_ready, dp_load, dp_round_en, idx[3:0], ks_shift[1:0], ks_dir, dp_final, out_valid, out_mode, busy}
  localparam logic [13:0] RST_VEC = 14'h2000;

  des_round_seq #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode), .in_ready(in_ready),
    .abort(abort), .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
    .ks_shift(ks_shift), .ks_dir(ks_dir), .dp_final(dp_final), .out_valid(out_valid),
    .out_ready(out_ready), .out_mode(out_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {in_ready, dp_load, dp_round_en, dp_round_idx, ks_shift, ks_dir,
            dp_final, out_valid, out_mode, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (mon_on)
      chk("onehot", 32'($countones({dp_load, dp_round_en, dp_final}) <= 1), 32'd1);

  // Full block from IDLE; hold = number of extra DONE cycles with out_ready low.
  task automatic run_block(input logic m, input int hold);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_mode   = m;
    chk("acc_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_mode  = ~m;
    chk("load", 32'({dp_load, dp_round_en, dp_final, ks_dir, busy, in_ready}),
        32'({3'b100, m, 1'b1, 1'b0}));
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("round%0d", i),
          32'({dp_round_en, dp_round_idx, ks_shift, ks_dir, dp_load, dp_final, out_valid}),
          32'({1'b1, 4'(i), (m ? dec_sh[i] : enc_sh[i]), m, 3'b000}));
    end
    tick();
    chk("final", 32'({dp_final, dp_round_en, dp_round_idx, ks_shift, ks_dir, out_valid}),
        32'({1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0}));
    tick();
    chk("done", 32'({out_valid, out_mode, in_ready, busy, ks_dir, ks_shift}),
        32'({1'b1, m, 1'b0, 1'b1, 1'b0, 2'd0}));
    for (int h = 1; h <= hold; h++) begin
      tick();
      chk($sformatf("hold%0d", h), 32'({out_valid, out_mode, in_ready}), 32'({1'b1, m, 1'b0}));
    end
    out_ready = 1'b1;
    tick();
    chk("ret_idle", 32'({in_ready, out_valid, busy}), 32'(3'b100));
  endtask

  initial begin
    tick();
    tick();
    chk("reset", 32'(outs()), 32'(RST_VEC));
    rst_n  = 1'b1;
    mon_on = 1'b1;
    tick();
    chk("idle", 32'(outs()), 32'(RST_VEC));

    run_block(1'b0, 0);
    run_block(1'b1, 0);
    run_block(1'b0, 5);

    // Abort at round 7
    in_valid = 1'b1; in_mode = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_abort", 32'({dp_round_en, dp_round_idx}), 32'({1'b1, 4'd7}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(outs()), 32'(RST_VEC));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_abort", 32'({dp_final, out_valid, busy}), 32'd0);
    end
    run_block(1'b0, 0);

    // Offer together with abort: not accepted
    in_valid = 1'b1; abort = 1'b1;
    tick();
    chk("abort_noacc", 32'(outs()), 32'(RST_VEC));
    in_valid = 1'b0; abort = 1'b0;

    // Abort wins over a DONE handshake in the same cycle
    in_valid = 1'b1; in_mode = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    chk("abort_done_pre", 32'({out_valid, out_mode}), 32'(2'b11));
    out_ready = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done", 32'(outs()), 32'(RST_VEC));

    // Reset mid-round
    in_valid = 1'b1; in_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst", 32'({dp_round_en, dp_round_idx, ks_dir}), 32'({1'b1, 4'd3, 1'b1}));
    rst_n = 1'b0; abort = 1'b1;
    tick();
    rst_n = 1'b1; abort = 1'b0;
    chk("mid_rst", 32'(outs()), 32'(RST_VEC));
    run_block(1'b1, 0);

    // Back-to-back with in_valid held high
    in_valid = 1'b1; in_mode = 1'b0; out_ready = 1'b1;
    chk("b2b_acc0", 32'(in_ready), 32'd1);
    for (int i = 0; i < 19; i++) tick();
    chk("b2b_done0", 32'({out_valid, in_ready}), 32'(2'b10));
    tick();
    chk("b2b_reacc", 32'({in_ready, dp_load, busy}), 32'(3'b100));
    tick();
    chk("b2b_load1", 32'({dp_load, in_ready}), 32'(2'b10));
    for (int i = 0; i < 18; i++) tick();
    chk("b2b_done1", 32'({out_valid, out_mode}), 32'(2'b10));
    in_valid = 1'b0;
    tick();
    chk("b2b_idle", 32'(outs()), 32'(RST_VEC));

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
